matmul_dma: RTL and testbench
=============================

// Module: matmul_dma
// PURPOSE
//   Bus initiator that feeds the matmul accelerator. On start it copies vector A (N words) and,
//   optionally, matrix B (N*N words, column-major) from system RAM into the accelerator window,
//   then copies the 2*N-word result (N x 64-bit) back to RAM. It is a master on the same
//   valid/ready memory bus the accelerator responds on, so the CPU only issues start and waits.
// PARAMETERS
//   N           4           chunk size; must match the accelerator
//   ACCEL_WRITE 'h1100000   accelerator input window base (A at +0, B at +4*N)
//   ACCEL_READ  'h1300000   accelerator result window base
//   TIMEOUT     1024        max cycles waiting for mem_ready on one transaction
// PORTS
//   clk         in   1   clock
//   rst         in   1   synchronous active-high reset
//   start       in   1   one-cycle request; sampled only when busy=0
//   load_b      in   1   1: load B this run; 0: skip B phase (reuse resident B)
//   src_a_addr  in   32  RAM address of A (word aligned)
//   src_b_addr  in   32  RAM address of B (word aligned)
//   dst_c_addr  in   32  RAM address for result (word aligned)
//   busy        out  1   high from accepted start until done
//   done        out  1   one-cycle pulse at end of run (success or error)
//   error       out  1   sticky timeout flag; cleared by next accepted start
//   mem_valid   out  1   bus request
//   mem_ready   in   1   bus acknowledge (registered by responders)
//   mem_addr    out  32  bus address
//   mem_wdata   out  32  write data
//   mem_wstrb   out  4   4'hF for writes, 4'h0 for reads
//   mem_rdata   in   32  read data, valid when mem_ready=1 on a read
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; counters 0. rst mid-run: mem_valid low the next cycle,
//   run abandoned, no done pulse.
// - start with busy=0: latch three addresses and load_b, clear error, busy=1, phase LOAD_A.
//   start while busy=1 ignored.
// - Phases, each a loop of word copies, word index k from 0:
//   LOAD_A : k<N,    read src_a_addr+4k  -> write ACCEL_WRITE+4k
//   LOAD_B : k<N*N,  read src_b_addr+4k  -> write ACCEL_WRITE+4N+4k   (skipped if load_b=0)
//   STORE_C: k<2N,   read ACCEL_READ+4k  -> write dst_c_addr+4k
// - Per word: RD (valid, wstrb=0) -> GAP -> WR (valid, wstrb=F, wdata=captured rdata) -> GAP.
// - Handshake: mem_valid/addr/wdata/wstrb held stable until mem_ready=1 is sampled; on that
//   edge rdata captured (reads) and mem_valid driven low. GAP is exactly one cycle with
//   mem_valid=0 and mem_ready ignored (responder ready is registered and may be stale for a cycle).
// - States: IDLE, RD, RD_GAP, WR, WR_GAP, FINISH. After WR_GAP: k++, or next phase
//   (k reset 0) when k hits phase count. After last STORE_C word -> FINISH: done=1 one cycle,
//   busy=0, -> IDLE.
// - Minimum cost 4 cycles/word with zero-wait responders: N=4, load_b=1 => 28 words, >=112 cycles.
// - Timeout: counter reset each time mem_valid rises; if it reaches TIMEOUT with mem_valid=1
//   and no mem_ready: mem_valid=0, error=1, -> FINISH (done pulses, busy drops). A late
//   mem_ready arriving in IDLE is ignored.
// - Address arithmetic modulo 2^32; no alignment checking. k counter width clog2(N*N+1).
// - mem_addr/mem_wstrb/mem_wdata may hold last values while mem_valid=0.
// TESTING
// 1. A=[1,2,3,4], B=identity, load_b=1, zero-wait RAM/accel models -> 4+16+8 reads and writes
//    in order; RAM at dst_c = [1,0,2,0,3,0,4,0]; done one pulse; error=0.
// 2. Repeat with A=[5,6,7,8], load_b=0 -> no access to src_b or ACCEL_WRITE+16..+79;
//    12 word copies; C=[5,0,6,0,7,0,8,0].
// 3. Random 0-5 cycle ready stalls -> valid/addr/wdata/wstrb stable each transaction,
//    one-cycle valid-low gap between transactions, result identical to test 1.
// 4. RAM never acks read of src_a_addr+8 -> after TIMEOUT cycles mem_valid=0, error=1,
//    done pulse, busy=0; next start clears error and completes normally.
// 5. rst asserted during LOAD_B word 7 -> next cycle mem_valid=0, busy=0, no done; fresh start
//    completes test 1 correctly.
// 6. start pulsed again mid-run with different addresses -> ignored; run uses original addresses.

Source files
------------

// File: rtl/matmul_dma.sv
// Bus-master copy engine for the matmul accelerator: moves A (and optionally B) into the
// accelerator input window, then moves the 2*N-word result back to system RAM.
module matmul_dma #(
    parameter int          N           = 4,
    parameter logic [31:0] ACCEL_WRITE = 32'h0110_0000,
    parameter logic [31:0] ACCEL_READ  = 32'h0130_0000,
    parameter int          TIMEOUT     = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        load_b,
    input  logic [31:0] src_a_addr,
    input  logic [31:0] src_b_addr,
    input  logic [31:0] dst_c_addr,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);
    localparam int KW = $clog2(N * N + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    // Handshake: mem_valid/addr/wdata/wstrb stay stable until mem_ready=1 is sampled on a
    // rising edge; each request is followed by one mem_valid=0 gap cycle in which mem_ready
    // is ignored, so a stale registered ready from the responder is never taken as an ack.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_RD_GAP = 3'd2,
        S_WR     = 3'd3,
        S_WR_GAP = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        P_LOAD_A  = 2'd0,
        P_LOAD_B  = 2'd1,
        P_STORE_C = 2'd2
    } phase_t;

    state_t        state_q, state_d;
    phase_t        phase_q, phase_d;
    logic [KW-1:0] k_q, k_d, k_last;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [31:0]   src_a_q, src_a_d;
    logic [31:0]   src_b_q, src_b_d;
    logic [31:0]   dst_c_q, dst_c_d;
    logic          load_b_q, load_b_d;
    logic          error_q, error_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_wstrb_q, mem_wstrb_d;
    logic          start_ok;
    logic          tmo_hit;
    logic          last_word;
    logic [31:0]   offset;
    logic [31:0]   rd_addr;
    logic [31:0]   wr_addr;

    // State register (and all datapath flops)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            phase_q     <= P_LOAD_A;
            k_q         <= '0;
            tmo_q       <= '0;
            src_a_q     <= '0;
            src_b_q     <= '0;
            dst_c_q     <= '0;
            load_b_q    <= 1'b0;
            error_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            k_q         <= k_d;
            tmo_q       <= tmo_d;
            src_a_q     <= src_a_d;
            src_b_q     <= src_b_d;
            dst_c_q     <= dst_c_d;
            load_b_q    <= load_b_d;
            error_q     <= error_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    always_comb begin
        k_last = KW'(2 * N - 1);
        unique case (phase_q)
            P_LOAD_A: k_last = KW'(N - 1);
            P_LOAD_B: k_last = KW'(N * N - 1);
            default:  k_last = KW'(2 * N - 1);
        endcase
    end

    assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_FINISH));
    assign last_word = (phase_q == P_STORE_C) && (k_q == k_last);
    assign tmo_hit   = mem_valid && !mem_ready && (tmo_q == TW'(TIMEOUT - 1));

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start_ok) state_d = S_RD;
            S_RD: begin
                if (mem_ready)    state_d = S_RD_GAP;
                else if (tmo_hit) state_d = S_FINISH;
            end
            S_RD_GAP: state_d = S_WR;
            S_WR: begin
                if (mem_ready)    state_d = S_WR_GAP;
                else if (tmo_hit) state_d = S_FINISH;
            end
            S_WR_GAP: state_d = last_word ? S_FINISH : S_RD;
            S_FINISH: state_d = start_ok ? S_RD : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mem_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            S_RD, S_WR: begin
                mem_valid = 1'b1;
                busy      = 1'b1;
            end
            S_RD_GAP, S_WR_GAP: busy = 1'b1;
            S_FINISH:           done = 1'b1;
            default: ;
        endcase
    end

    // Phase / word index advance and run-parameter latching
    always_comb begin
        phase_d  = phase_q;
        k_d      = k_q;
        src_a_d  = src_a_q;
        src_b_d  = src_b_q;
        dst_c_d  = dst_c_q;
        load_b_d = load_b_q;
        error_d  = error_q;
        if (start_ok) begin
            src_a_d  = src_a_addr;
            src_b_d  = src_b_addr;
            dst_c_d  = dst_c_addr;
            load_b_d = load_b;
            error_d  = 1'b0;
            phase_d  = P_LOAD_A;
            k_d      = '0;
        end else if (state_q == S_WR_GAP) begin
            if (k_q == k_last) begin
                k_d = '0;
                unique case (phase_q)
                    P_LOAD_A: phase_d = load_b_q ? P_LOAD_B : P_STORE_C;
                    P_LOAD_B: phase_d = P_STORE_C;
                    default:  phase_d = phase_q;
                endcase
            end else begin
                k_d = k_q + KW'(1);
            end
        end
        if (tmo_hit) error_d = 1'b1;
    end

    // Addresses are computed from the upcoming phase/index so they are ready on valid rise
    always_comb begin
        offset  = 32'(k_d) << 2;
        rd_addr = ACCEL_READ + offset;
        wr_addr = dst_c_d + offset;
        unique case (phase_d)
            P_LOAD_A: begin
                rd_addr = src_a_d + offset;
                wr_addr = ACCEL_WRITE + offset;
            end
            P_LOAD_B: begin
                rd_addr = src_b_d + offset;
                wr_addr = ACCEL_WRITE + 32'(4 * N) + offset;
            end
            default: begin
                rd_addr = ACCEL_READ + offset;
                wr_addr = dst_c_d + offset;
            end
        endcase
    end

    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        tmo_d       = tmo_q;
        if ((state_d == S_RD) && (state_q != S_RD)) begin
            mem_addr_d  = rd_addr;
            mem_wstrb_d = 4'h0;
        end
        if ((state_d == S_WR) && (state_q != S_WR)) begin
            mem_addr_d  = wr_addr;
            mem_wstrb_d = 4'hF;
        end
        if ((state_q == S_RD) && mem_ready) mem_wdata_d = mem_rdata;
        if (state_d != state_q) tmo_d = '0;
        else if (mem_valid)     tmo_d = tmo_q + TW'(1);
    end

    assign error     = error_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_matmul_dma.sv
// Directed bench for matmul_dma: RAM + accelerator responder model, handshake monitor,
// and one task per scenario with inline checks against hand-computed results.
module tb_matmul_dma;
    localparam int          N     = 4;
    localparam int          TMO   = 1024;
    localparam logic [31:0] AW    = 32'h0110_0000;
    localparam logic [31:0] AR    = 32'h0130_0000;
    localparam logic [31:0] SRC_A = 32'h0000_1000;
    localparam logic [31:0] SRC_B = 32'h0000_2000;
    localparam logic [31:0] DST_C = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst, start, load_b;
    logic [31:0] src_a_addr, src_b_addr, dst_c_addr;
    logic        busy, done, error, mem_valid, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] ram [logic [31:0]];
    logic [31:0] accel_in [0:N+N*N-1];
    logic [31:0] a_vals [4];
    logic [31:0] c_vals [8];
    logic [64:0] log_q [$];
    logic [64:0] exp_q [$];

    int   max_stall = 0;
    int   stall_cnt = 0;
    bit   block_en = 0;
    logic [31:0] block_addr = '0;
    bit   late_ack = 0;
    bit   chk_en = 1;
    int   done_cnt = 0;
    int   viol = 0;
    int   valid_run = 0;
    int   max_valid_run = 0;
    bit   p_valid = 0, p_ready = 0, p_ack = 0, pp_ack = 0;
    logic [31:0] p_addr = '0, p_wdata = '0;
    logic [3:0]  p_wstrb = '0;

    matmul_dma #(.N(N), .ACCEL_WRITE(AW), .ACCEL_READ(AR), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .load_b(load_b),
        .src_a_addr(src_a_addr), .src_b_addr(src_b_addr), .dst_c_addr(dst_c_addr),
        .busy(busy), .done(done), .error(error),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Accelerator result word: c_i = sum_j B[i][j] * A[j], B column-major
    function automatic logic [31:0] accel_rd(input logic [31:0] a);
        int w;
        int i;
        logic [63:0] s;
        w = int'((a - AR) >> 2);
        i = w / 2;
        s = '0;
        for (int j = 0; j < N; j++) s = s + 64'(accel_in[N + j * N + i]) * 64'(accel_in[j]);
        return (w % 2 == 1) ? s[63:32] : s[31:0];
    endfunction

    // Responder: registered one-cycle ready after an optional random stall
    always @(posedge clk) begin
        mem_ready <= 1'b0;
        if (late_ack) begin
            mem_ready <= 1'b1;
        end else if (mem_valid && !mem_ready) begin
            if (stall_cnt > 0) begin
                stall_cnt = stall_cnt - 1;
            end else if (!(block_en && mem_addr == block_addr && mem_wstrb == 4'h0)) begin
                mem_ready <= 1'b1;
                stall_cnt = int'($urandom_range(0, max_stall));
                if (mem_wstrb == 4'hF) begin
                    if (mem_addr >= AW && mem_addr < AW + 32'(4 * (N + N * N)))
                        accel_in[int'((mem_addr - AW) >> 2)] = mem_wdata;
                    else
                        ram[mem_addr] = mem_wdata;
                end else if (mem_addr >= AR && mem_addr < AR + 32'(8 * N)) begin
                    mem_rdata <= accel_rd(mem_addr);
                end else begin
                    mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : 32'h0;
                end
            end
        end
    end

    // Monitor: transaction log, done pulses, valid run lengths, handshake rule violations
    always @(negedge clk) begin
        if (mem_valid && mem_ready)
            log_q.push_back({mem_wstrb == 4'hF, mem_addr, (mem_wstrb == 4'hF) ? mem_wdata : mem_rdata});
        if (done) done_cnt++;
        valid_run = mem_valid ? valid_run + 1 : 0;
        if (valid_run > max_valid_run) max_valid_run = valid_run;
        if (chk_en && !rst) begin
            if (p_valid && !p_ready &&
                !(mem_valid && mem_addr == p_addr && mem_wdata == p_wdata && mem_wstrb == p_wstrb))
                viol++;
            if (p_ack && mem_valid) viol++;
            if (pp_ack && busy && !mem_valid) viol++;
        end
        pp_ack  = p_ack;
        p_ack   = mem_valid && mem_ready;
        p_valid = mem_valid;
        p_ready = mem_ready;
        p_addr  = mem_addr;
        p_wdata = mem_wdata;
        p_wstrb = mem_wstrb;
    end

    // Driver tasks
    task automatic set_a(input logic [31:0] v0, v1, v2, v3);
        a_vals = '{v0, v1, v2, v3};
        for (int k = 0; k < N; k++) ram[SRC_A + 32'(4 * k)] = a_vals[k];
        for (int k = 0; k < 2 * N; k++) ram[DST_C + 32'(4 * k)] = 32'hDEAD_BEEF;
        c_vals = '{v0, 32'h0, v1, 32'h0, v2, 32'h0, v3, 32'h0};
    endtask

    task automatic build_exp(input logic [31:0] a, b, c, input logic lb);
        exp_q.delete();
        for (int k = 0; k < N; k++) begin
            exp_q.push_back({1'b0, 32'(a + 32'(4 * k)), a_vals[k]});
            exp_q.push_back({1'b1, 32'(AW + 32'(4 * k)), a_vals[k]});
        end
        if (lb) for (int k = 0; k < N * N; k++) begin
            exp_q.push_back({1'b0, 32'(b + 32'(4 * k)), 32'((k % (N + 1) == 0) ? 1 : 0)});
            exp_q.push_back({1'b1, 32'(AW + 32'(4 * N + 4 * k)), 32'((k % (N + 1) == 0) ? 1 : 0)});
        end
        for (int k = 0; k < 2 * N; k++) begin
            exp_q.push_back({1'b0, 32'(AR + 32'(4 * k)), c_vals[k]});
            exp_q.push_back({1'b1, 32'(c + 32'(4 * k)), c_vals[k]});
        end
    endtask

    task automatic start_job(input logic [31:0] a, b, c, input logic lb);
        @(negedge clk);
        log_q.delete();
        done_cnt = 0;
        viol = 0;
        max_valid_run = 0;
        src_a_addr = a;
        src_b_addr = b;
        dst_c_addr = c;
        load_b = lb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit to);
        cyc = 1;
        to = 1;
        for (int i = 0; i < 5000; i++) begin
            if (done === 1'b1) begin
                to = 0;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    // Scenarios
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt += 7;
        if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else pass_cnt++;
        if (done !== 1'b0) $display("FAIL rst_done got %b exp 0", done); else pass_cnt++;
        if (error !== 1'b0) $display("FAIL rst_error got %b exp 0", error); else pass_cnt++;
        if (mem_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", mem_valid); else pass_cnt++;
        if (mem_addr !== 32'h0) $display("FAIL rst_addr got %h exp 0", mem_addr); else pass_cnt++;
        if (mem_wdata !== 32'h0) $display("FAIL rst_wdata got %h exp 0", mem_wdata); else pass_cnt++;
        if (mem_wstrb !== 4'h0) $display("FAIL rst_wstrb got %h exp 0", mem_wstrb); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_identity();
        int cyc;
        bit to;
        set_a(1, 2, 3, 4);
        max_stall = 0;
        build_exp(SRC_A, SRC_B, DST_C, 1'b1);
        start_job(SRC_A, SRC_B, DST_C, 1'b1);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL t1_busy_after_start got %b exp 1", busy); else pass_cnt++;
        wait_done(cyc, to);
        total_cnt += 4;
        if (to) $display("FAIL t1_done_timeout got none exp done"); else pass_cnt++;
        if (busy !== 1'b0) $display("FAIL t1_busy_at_done got %b exp 0", busy); else pass_cnt++;
        if (error !== 1'b0) $display("FAIL t1_error got %b exp 0", error); else pass_cnt++;
        if (cyc < 112) $display("FAIL t1_cycles got %0d exp >=112", cyc); else pass_cnt++;
        repeat (3) @(negedge clk);
        total_cnt += 3;
        if (done_cnt !== 1) $display("FAIL t1_done_pulses got %0d exp 1", done_cnt); else pass_cnt++;
        if (viol !== 0) $display("FAIL t1_handshake got %0d violations exp 0", viol); else pass_cnt++;
        if (log_q.size() !== 56) $display("FAIL t1_txn_count got %0d exp 56", log_q.size()); else pass_cnt++;
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            total_cnt++;
            if (log_q[i] !== exp_q[i]) $display("FAIL t1_txn[%0d] got %h exp %h", i, log_q[i], exp_q[i]);
            else pass_cnt++;
        end
        for (int k = 0; k < 2 * N; k++) begin
            total_cnt++;
            if (ram[DST_C + 32'(4 * k)] !== c_vals[k])
                $display("FAIL t1_c[%0d] got %h exp %h", k, ram[DST_C + 32'(4 * k)], c_vals[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reuse_b();
        int cyc;
        bit to;
        set_a(5, 6, 7, 8);
        build_exp(SRC_A, SRC_B, DST_C, 1'b0);
        start_job(SRC_A, SRC_B, DST_C, 1'b0);
        wait_done(cyc, to);
        repeat (3) @(negedge clk);
        total_cnt += 3;
        if (to) $display("FAIL t2_done_timeout got none exp done"); else pass_cnt++;
        if (log_q.size() !== 24) $display("FAIL t2_txn_count got %0d exp 24", log_q.size()); else pass_cnt++;
        if (done_cnt !== 1) $display("FAIL t2_done_pulses got %0d exp 1", done_cnt); else pass_cnt++;
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            total_cnt++;
            if (log_q[i] !== exp_q[i]) $display("FAIL t2_txn[%0d] got %h exp %h", i, log_q[i], exp_q[i]);
            else pass_cnt++;
        end
        for (int k = 0; k < 2 * N; k++) begin
            total_cnt++;
            if (ram[DST_C + 32'(4 * k)] !== c_vals[k])
                $display("FAIL t2_c[%0d] got %h exp %h", k, ram[DST_C + 32'(4 * k)], c_vals[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_stalls();
        int cyc;
        bit to;
        set_a(1, 2, 3, 4);
        max_stall = 5;
        start_job(SRC_A, SRC_B, DST_C, 1'b1);
        wait_done(cyc, to);
        repeat (3) @(negedge clk);
        max_stall = 0;
        stall_cnt = 0;
        total_cnt += 4;
        if (to) $display("FAIL t3_done_timeout got none exp done"); else pass_cnt++;
        if (viol !== 0) $display("FAIL t3_handshake got %0d violations exp 0", viol); else pass_cnt++;
        if (max_valid_run > 7) $display("FAIL t3_valid_run got %0d exp <=7", max_valid_run); else pass_cnt++;
        if (log_q.size() !== 56) $display("FAIL t3_txn_count got %0d exp 56", log_q.size()); else pass_cnt++;
        for (int k = 0; k < 2 * N; k++) begin
            total_cnt++;
            if (ram[DST_C + 32'(4 * k)] !== c_vals[k])
                $display("FAIL t3_c[%0d] got %h exp %h", k, ram[DST_C + 32'(4 * k)], c_vals[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_timeout();
        int cyc;
        bit to;
        set_a(1, 2, 3, 4);
        chk_en = 0;
        block_en = 1;
        block_addr = SRC_A + 32'h8;
        start_job(SRC_A, SRC_B, DST_C, 1'b1);
        wait_done(cyc, to);
        total_cnt += 5;
        if (to) $display("FAIL t4_done_timeout got none exp done"); else pass_cnt++;
        if (mem_valid !== 1'b0) $display("FAIL t4_valid got %b exp 0", mem_valid); else pass_cnt++;
        if (error !== 1'b1) $display("FAIL t4_error got %b exp 1", error); else pass_cnt++;
        if (busy !== 1'b0) $display("FAIL t4_busy got %b exp 0", busy); else pass_cnt++;
        if (max_valid_run !== TMO) $display("FAIL t4_wait_len got %0d exp %0d", max_valid_run, TMO); else pass_cnt++;
        @(negedge clk);
        late_ack = 1;
        @(negedge clk);
        late_ack = 0;
        repeat (4) @(negedge clk);
        total_cnt += 4;
        if (done_cnt !== 1) $display("FAIL t4_done_pulses got %0d exp 1", done_cnt); else pass_cnt++;
        if (busy !== 1'b0 || mem_valid !== 1'b0)
            $display("FAIL t4_late_ack got busy=%b valid=%b exp 0/0", busy, mem_valid); else pass_cnt++;
        if (error !== 1'b1) $display("FAIL t4_error_sticky got %b exp 1", error); else pass_cnt++;
        block_en = 0;
        chk_en = 1;
        start_job(SRC_A, SRC_B, DST_C, 1'b1);
        if (error !== 1'b0) $display("FAIL t4_error_clear got %b exp 0", error); else pass_cnt++;
        wait_done(cyc, to);
        repeat (3) @(negedge clk);
        total_cnt += 2;
        if (to) $display("FAIL t4_rerun_timeout got none exp done"); else pass_cnt++;
        if (error !== 1'b0) $display("FAIL t4_rerun_error got %b exp 0", error); else pass_cnt++;
        for (int k = 0; k < 2 * N; k++) begin
            total_cnt++;
            if (ram[DST_C + 32'(4 * k)] !== c_vals[k])
                $display("FAIL t4_c[%0d] got %h exp %h", k, ram[DST_C + 32'(4 * k)], c_vals[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        bit to;
        bit seen;
        set_a(1, 2, 3, 4);
        chk_en = 0;
        start_job(SRC_A, SRC_B, DST_C, 1'b1);
        seen = 0;
        for (int i = 0; i < 2000; i++) begin
            if (mem_valid && mem_wstrb == 4'h0 && mem_addr == SRC_B + 32'd28) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        total_cnt += 4;
        if (!seen) $display("FAIL t5_reach_b7 got none exp read of B word 7"); else pass_cnt++;
        rst = 1'b1;
        done_cnt = 0;
        @(negedge clk);
        if (mem_valid !== 1'b0) $display("FAIL t5_valid got %b exp 0", mem_valid); else pass_cnt++;
        if (busy !== 1'b0) $display("FAIL t5_busy got %b exp 0", busy); else pass_cnt++;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        if (done_cnt !== 0) $display("FAIL t5_no_done got %0d exp 0", done_cnt); else pass_cnt++;
        chk_en = 1;
        set_a(1, 2, 3, 4);
        start_job(SRC_A, SRC_B, DST_C, 1'b1);
        wait_done(cyc, to);
        repeat (3) @(negedge clk);
        total_cnt += 2;
        if (to) $display("FAIL t5_rerun_timeout got none exp done"); else pass_cnt++;
        if (viol !== 0) $display("FAIL t5_handshake got %0d violations exp 0", viol); else pass_cnt++;
        for (int k = 0; k < 2 * N; k++) begin
            total_cnt++;
            if (ram[DST_C + 32'(4 * k)] !== c_vals[k])
                $display("FAIL t5_c[%0d] got %h exp %h", k, ram[DST_C + 32'(4 * k)], c_vals[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_start_ignored();
        int cyc;
        bit to;
        set_a(1, 2, 3, 4);
        build_exp(SRC_A, SRC_B, DST_C, 1'b1);
        start_job(SRC_A, SRC_B, DST_C, 1'b1);
        repeat (10) @(negedge clk);
        src_a_addr = 32'h5000;
        src_b_addr = 32'h6000;
        dst_c_addr = 32'h7000;
        load_b = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, to);
        repeat (3) @(negedge clk);
        total_cnt += 4;
        if (to) $display("FAIL t6_done_timeout got none exp done"); else pass_cnt++;
        if (done_cnt !== 1) $display("FAIL t6_done_pulses got %0d exp 1", done_cnt); else pass_cnt++;
        if (log_q.size() !== 56) $display("FAIL t6_txn_count got %0d exp 56", log_q.size()); else pass_cnt++;
        if (ram.exists(32'h7000)) $display("FAIL t6_alt_dst got written exp untouched"); else pass_cnt++;
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            total_cnt++;
            if (log_q[i] !== exp_q[i]) $display("FAIL t6_txn[%0d] got %h exp %h", i, log_q[i], exp_q[i]);
            else pass_cnt++;
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        load_b = 1'b0;
        src_a_addr = '0;
        src_b_addr = '0;
        dst_c_addr = '0;
        for (int i = 0; i < N + N * N; i++) accel_in[i] = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                ram[SRC_B + 32'(4 * (j * N + i))] = (i == j) ? 32'h1 : 32'h0;
        test_reset();
        test_identity();
        test_reuse_b();
        test_stalls();
        test_start_ignored();
        test_timeout();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
